// File: rtl/regfile_multiport_pkg.sv
// Shared types for the multiport register file: scrub FSM states and the
// default-geometry address type used by decode.
package regfile_multiport_pkg;

   localparam int unsigned RF_DEFAULT_DEPTH = 32;
   localparam int unsigned RF_DEFAULT_ADDR_W = $clog2(RF_DEFAULT_DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StDone
   } regfile_state_e;

   typedef logic [RF_DEFAULT_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: per-entry mux over the stored entries, then
// zero-entry / bypass priority. With REGFILE_PARITY_EN defined it also flags
// a parity mismatch on the stored word it returns.
module regfile_read_port
   import regfile_multiport_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = RF_DEFAULT_DEPTH,
   parameter int unsigned NUM_WRITE = 1,
   parameter bit          BYPASS    = 1'b0,
   parameter bit          ZERO_REG  = 1'b1,
   localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
   input  logic [DEPTH*WIDTH-1:0]      entries_i,
`ifdef REGFILE_PARITY_EN
   input  logic [DEPTH-1:0]            parity_i,
   output logic                        parity_err_o,
`endif
   input  logic [ADDR_W-1:0]           rd_addr_i,
   input  logic [NUM_WRITE-1:0]        wr_en_i,
   input  logic [NUM_WRITE*ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WRITE*WIDTH-1:0]  wr_data_i,
   output logic [WIDTH-1:0]            rd_data_o
);

   logic [WIDTH-1:0] stored;
   logic             stored_par;
   logic [WIDTH-1:0] byp_data;
   logic             byp_hit;
   logic             is_zero;

   // Per-entry select of the stored word (and its parity bit).
   always_comb begin
      stored     = '0;
      stored_par = 1'b0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
         if (rd_addr_i == ADDR_W'(e)) begin
            stored = entries_i[e*WIDTH +: WIDTH];
`ifdef REGFILE_PARITY_EN
            stored_par = parity_i[e];
`endif
         end
      end
   end

   // Same-cycle forwarding; later ports override earlier ones so port 1 wins.
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int unsigned j = 0; j < NUM_WRITE; j++) begin
         if (BYPASS && wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i)) begin
            byp_hit  = 1'b1;
            byp_data = wr_data_i[j*WIDTH +: WIDTH];
         end
      end
   end

   // Output priority: hardwired zero, then bypass, then storage.
   always_comb begin
      is_zero = ZERO_REG && (rd_addr_i == '0);
      if (is_zero) begin
         rd_data_o = '0;
      end else if (byp_hit) begin
         rd_data_o = byp_data;
      end else begin
         rd_data_o = stored ^ {WIDTH{stored_par & 1'b0}};
      end
   end

`ifdef REGFILE_PARITY_EN
   // Only words actually coming out of storage are checked.
   assign parity_err_o = !is_zero && !byp_hit && ((^stored) != stored_par);
`endif

endmodule

// File: rtl/regfile_multiport.sv
// Multiport integer register file with hardwired zero entry, optional bypass
// and a sequential scrub engine. Optional parity protection is enabled by
// defining REGFILE_PARITY_EN.
module regfile_multiport
   import regfile_multiport_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH       = RF_DEFAULT_DEPTH,
   parameter int unsigned NUM_READ    = 2,
   parameter int unsigned NUM_WRITE   = 1,
   parameter bit          BYPASS      = 1'b0,
   parameter bit          ZERO_REG    = 1'b1,
   parameter int unsigned DEBUG_INDEX = 31,
   localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_READ*ADDR_W-1:0]  rd_addr,
   output logic [NUM_READ*WIDTH-1:0]   rd_data,
   input  logic [NUM_WRITE-1:0]        wr_en,
   input  logic [NUM_WRITE*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WRITE*WIDTH-1:0]  wr_data,
   input  logic                        clear_req,
   output logic                        clear_busy,
   output logic [WIDTH-1:0]            debug_out,
   output logic                        parity_err
);

   localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DEBUG_INDEX);

   logic [WIDTH-1:0]       mem_q [DEPTH];
   logic [WIDTH-1:0]       mem_d [DEPTH];
   logic [DEPTH*WIDTH-1:0] mem_flat;
   regfile_state_e         state_q, state_d;
   logic [ADDR_W-1:0]      ptr_q, ptr_d;
   logic                   busy_q, busy_d;

`ifdef REGFILE_PARITY_EN
   logic [DEPTH-1:0]    par_q, par_d;
   logic [NUM_READ-1:0] port_err;
   logic                err_q, err_d;
`endif

   // Write decode: scrub clears entry[ptr]; functional writes override it,
   // and later write ports override earlier ones.
   always_comb begin
      mem_d = mem_q;
`ifdef REGFILE_PARITY_EN
      par_d = par_q;
`endif
      if (state_q == StClear) begin
         mem_d[ptr_q] = '0;
`ifdef REGFILE_PARITY_EN
         par_d[ptr_q] = 1'b0;
`endif
      end
      for (int unsigned j = 0; j < NUM_WRITE; j++) begin
         if (wr_en[j] && !(ZERO_REG && (wr_addr[j*ADDR_W +: ADDR_W] == '0))) begin
            mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*WIDTH +: WIDTH];
`ifdef REGFILE_PARITY_EN
            par_d[wr_addr[j*ADDR_W +: ADDR_W]] = ^wr_data[j*WIDTH +: WIDTH];
`endif
         end
      end
   end

   // Entry storage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`ifdef REGFILE_PARITY_EN
         par_q <= '0;
`endif
      end else begin
         mem_q <= mem_d;
`ifdef REGFILE_PARITY_EN
         par_q <= par_d;
`endif
      end
   end

   // Scrub FSM next state; ptr stops at DEPTH-1 so it never wraps.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (clear_req) begin
               state_d = StClear;
               ptr_d   = ZERO_REG ? ADDR_W'(1) : '0;
            end
         end
         StClear: begin
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = StDone;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   // Scrub FSM state and registered busy flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   assign clear_busy = busy_q;

   // Flatten storage for the read-port muxes.
   always_comb begin
      mem_flat = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      regfile_read_port #(
         .WIDTH     (WIDTH),
         .DEPTH     (DEPTH),
         .NUM_WRITE (NUM_WRITE),
         .BYPASS    (BYPASS),
         .ZERO_REG  (ZERO_REG)
      ) u_rd (
         .entries_i    (mem_flat),
`ifdef REGFILE_PARITY_EN
         .parity_i     (par_q),
         .parity_err_o (port_err[i]),
`endif
         .rd_addr_i    (rd_addr[i*ADDR_W +: ADDR_W]),
         .wr_en_i      (wr_en),
         .wr_addr_i    (wr_addr),
         .wr_data_i    (wr_data),
         .rd_data_o    (rd_data[i*WIDTH +: WIDTH])
      );
   end

   assign debug_out = (ZERO_REG && (DBG_IDX == '0)) ? '0 : mem_q[DBG_IDX];

`ifdef REGFILE_PARITY_EN
   // Sticky parity error, cleared only by reset.
   always_comb begin
      err_d = err_q | (|port_err);
   end

   // Parity error flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign parity_err = err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: two register-file instances share stimulus. Instance A
// has ZERO_REG=1, BYPASS=0; instance B has ZERO_REG=0, BYPASS=1. Both have
// two write ports. Stimulus pushes expected values; a monitor compares them
// on the falling edge.
module tb_regfile_multiport;

   localparam int SEL_A_RD0 = 0;
   localparam int SEL_A_RD1 = 1;
   localparam int SEL_A_DBG = 2;
   localparam int SEL_A_BSY = 3;
   localparam int SEL_A_PER = 4;
   localparam int SEL_B_RD0 = 5;
   localparam int SEL_B_RD1 = 6;
   localparam int SEL_B_PER = 7;
   localparam int SEL_B_BSY = 8;
   localparam int SEL_B_DBG = 9;

   logic        clock;
   logic        reset;
   logic [9:0]  rd_addr;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        a_clear_req;
   logic        b_clear_req;
   logic [63:0] a_rd_data, b_rd_data;
   logic [31:0] a_debug, b_debug;
   logic        a_busy, b_busy, a_perr, b_perr;

   int          sel_q[$];
   logic [31:0] exp_q[$];
   string       name_q[$];
   int          n_checks;
   int          n_pass;

   regfile_multiport #(
      .WIDTH(32), .DEPTH(32), .NUM_READ(2), .NUM_WRITE(2),
      .BYPASS(1'b0), .ZERO_REG(1'b1), .DEBUG_INDEX(31)
   ) u_dut_a (
      .clock      (clock),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .rd_data    (a_rd_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .clear_req  (a_clear_req),
      .clear_busy (a_busy),
      .debug_out  (a_debug),
      .parity_err (a_perr)
   );

   regfile_multiport #(
      .WIDTH(32), .DEPTH(32), .NUM_READ(2), .NUM_WRITE(2),
      .BYPASS(1'b1), .ZERO_REG(1'b0), .DEBUG_INDEX(31)
   ) u_dut_b (
      .clock      (clock),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .rd_data    (b_rd_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .clear_req  (b_clear_req),
      .clear_busy (b_busy),
      .debug_out  (b_debug),
      .parity_err (b_perr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_A_RD0: return a_rd_data[31:0];
         SEL_A_RD1: return a_rd_data[63:32];
         SEL_A_DBG: return a_debug;
         SEL_A_BSY: return {31'b0, a_busy};
         SEL_A_PER: return {31'b0, a_perr};
         SEL_B_RD0: return b_rd_data[31:0];
         SEL_B_RD1: return b_rd_data[63:32];
         SEL_B_PER: return {31'b0, b_perr};
         SEL_B_BSY: return {31'b0, b_busy};
         SEL_B_DBG: return b_debug;
         default:   return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
      sel_q.push_back(sel);
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   task automatic set_rd(input int p, input int a);
      rd_addr[p*5 +: 5] = a[4:0];
   endtask

   task automatic set_wr(input int p, input logic en, input int a, input logic [31:0] d);
      wr_en[p]           = en;
      wr_addr[p*5 +: 5]  = a[4:0];
      wr_data[p*32 +: 32] = d;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Monitor: compare every pending expectation against the live outputs.
   initial begin
      int          sel;
      logic [31:0] exp;
      logic [31:0] obs;
      string       name;
      forever begin
         @(negedge clock);
         while (sel_q.size() > 0) begin
            sel  = sel_q.pop_front();
            exp  = exp_q.pop_front();
            name = name_q.pop_front();
            obs  = observe(sel);
            n_checks++;
            if (obs === exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", name, obs, exp);
         end
      end
   end

   // Stimulus.
   initial begin
      n_checks    = 0;
      n_pass      = 0;
      reset       = 1'b1;
      rd_addr     = '0;
      wr_en       = '0;
      wr_addr     = '0;
      wr_data     = '0;
      a_clear_req = 1'b0;
      b_clear_req = 1'b0;
      set_rd(0, 5);
      expect_val(SEL_A_RD0, 32'h0, "reset_rd5");
      expect_val(SEL_A_BSY, 32'h0, "reset_busy");
      expect_val(SEL_A_PER, 32'h0, "reset_parity");
      expect_val(SEL_A_DBG, 32'h0, "reset_debug");
      expect_val(SEL_B_RD0, 32'h0, "reset_b_rd5");
      next_cycle();
      reset = 1'b0;
      next_cycle();

      // Write x5, then read it back next cycle.
      set_wr(0, 1'b1, 5, 32'hDEADBEEF);
      expect_val(SEL_A_RD0, 32'h0, "nobyp_same_cycle_x5");
      expect_val(SEL_B_RD0, 32'hDEADBEEF, "byp_same_cycle_x5");
      next_cycle();
      wr_en = '0;
      expect_val(SEL_A_RD0, 32'hDEADBEEF, "read_x5");
      expect_val(SEL_B_RD0, 32'hDEADBEEF, "b_read_x5");
      expect_val(SEL_A_DBG, 32'h0, "debug_x31_zero");
      next_cycle();

      // Entry 0: hardwired zero on A, ordinary storage (with bypass) on B.
      set_wr(0, 1'b1, 0, 32'h1234);
      set_rd(0, 0);
      expect_val(SEL_A_RD0, 32'h0, "zero_same_cycle");
      expect_val(SEL_B_RD0, 32'h1234, "b_x0_bypass");
      next_cycle();
      wr_en = '0;
      expect_val(SEL_A_RD0, 32'h0, "zero_next_cycle");
      expect_val(SEL_B_RD0, 32'h1234, "b_x0_stored");
      next_cycle();

      // Bypass of x7.
      set_wr(0, 1'b1, 7, 32'hA5A5A5A5);
      set_rd(1, 7);
      expect_val(SEL_A_RD1, 32'h0, "nobyp_x7_old");
      expect_val(SEL_B_RD1, 32'hA5A5A5A5, "byp_x7");
      next_cycle();
      wr_en = '0;
      expect_val(SEL_A_RD1, 32'hA5A5A5A5, "read_x7");
      next_cycle();

      // Write collision on x3: port 1 wins for storage and bypass.
      set_wr(0, 1'b1, 3, 32'h11);
      set_wr(1, 1'b1, 3, 32'h22);
      set_rd(0, 3);
      expect_val(SEL_A_RD0, 32'h0, "collide_same_cycle");
      expect_val(SEL_B_RD0, 32'h22, "b_collide_bypass");
      next_cycle();
      wr_en = '0;
      expect_val(SEL_A_RD0, 32'h22, "collide_x3");
      expect_val(SEL_B_RD0, 32'h22, "b_collide_x3");
      next_cycle();

      // Debug port tracks x31.
      set_wr(0, 1'b1, 31, 32'hCAFEF00D);
      next_cycle();
      wr_en = '0;
      expect_val(SEL_A_DBG, 32'hCAFEF00D, "debug_x31");
      expect_val(SEL_B_DBG, 32'hCAFEF00D, "b_debug_x31");
      next_cycle();

      // Fill entries 1..31 with 0x1000+i.
      for (int i = 1; i < 32; i += 2) begin
         set_wr(0, 1'b1, i, 32'h1000 + i);
         set_wr(1, (i + 1) < 32, i + 1, 32'h1000 + i + 1);
         next_cycle();
      end
      wr_en = '0;

      // Scrub A: 31 CLEAR cycles + 1 DONE cycle.
      a_clear_req = 1'b1;
      next_cycle();
      a_clear_req = 1'b0;
      for (int k = 0; k < 32; k++) begin
         expect_val(SEL_A_BSY, 32'h1, "scrub_busy");
         if (k == 0) begin
            set_rd(1, 20);
            expect_val(SEL_A_RD1, 32'h1014, "scrub_old_x20");
            expect_val(SEL_B_RD1, 32'h1014, "b_x20");
         end
         set_wr(0, k == 30, 31, 32'h55);
         a_clear_req = (k == 31);
         next_cycle();
         a_clear_req = 1'b0;
      end
      wr_en = '0;
      expect_val(SEL_A_BSY, 32'h0, "scrub_done");
      expect_val(SEL_B_BSY, 32'h0, "b_never_busy");
      next_cycle();
      expect_val(SEL_A_BSY, 32'h0, "done_req_dropped");
      expect_val(SEL_A_DBG, 32'h55, "debug_write_wins");

      for (int a = 0; a < 32; a += 2) begin
         set_rd(0, a);
         set_rd(1, a + 1);
         expect_val(SEL_A_RD0, 32'h0, "scrubbed_even");
         expect_val(SEL_A_RD1, (a + 1 == 31) ? 32'h55 : 32'h0, "scrubbed_odd");
         expect_val(SEL_B_RD0, (a == 0) ? 32'h1234 : 32'h1000 + a, "b_kept_even");
         expect_val(SEL_B_RD1, (a + 1 == 31) ? 32'h55 : 32'h1000 + a + 1, "b_kept_odd");
         next_cycle();
      end
      expect_val(SEL_A_PER, 32'h0, "no_parity_err");
      expect_val(SEL_B_PER, 32'h0, "b_no_parity_err");

      // Reset in the middle of a scrub.
      a_clear_req = 1'b1;
      next_cycle();
      a_clear_req = 1'b0;
      for (int k = 0; k < 4; k++) next_cycle();
      expect_val(SEL_A_BSY, 32'h1, "busy_before_reset");
      next_cycle();
      reset = 1'b1;
      set_rd(0, 31);
      expect_val(SEL_A_BSY, 32'h0, "reset_mid_scrub_busy");
      expect_val(SEL_A_RD0, 32'h0, "reset_mid_scrub_x31");
      expect_val(SEL_A_DBG, 32'h0, "reset_mid_scrub_debug");
      expect_val(SEL_B_RD0, 32'h0, "b_reset_x31");
      next_cycle();
      reset = 1'b0;
      next_cycle();
      expect_val(SEL_A_BSY, 32'h0, "idle_after_reset");

`ifdef REGFILE_PARITY_EN
      set_wr(0, 1'b1, 9, 32'h7);
      next_cycle();
      wr_en = '0;
      set_rd(0, 9);
      expect_val(SEL_A_PER, 32'h0, "parity_clean_x9");
      next_cycle();
      u_dut_a.mem_q[9][4] = ~u_dut_a.mem_q[9][4];
      next_cycle();
      expect_val(SEL_A_PER, 32'h1, "parity_set");
      set_rd(0, 5);
      next_cycle();
      next_cycle();
      expect_val(SEL_A_PER, 32'h1, "parity_sticky");
      expect_val(SEL_B_PER, 32'h0, "b_parity_clean");
      next_cycle();
      reset = 1'b1;
      expect_val(SEL_A_PER, 32'h0, "parity_reset");
      next_cycle();
      reset = 1'b0;
`endif

      next_cycle();
      next_cycle();
      if (sel_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expected 0", sel_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
